// File: rtl/minibit_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minibit_bus_pkg
// Purpose  : Shared types and constants for the 8-bit register bus arbiter.
// Revision : 1.0
// ============================================================================
package minibit_bus_pkg;

  localparam int N_REQ = 4;
  localparam int N_REG = 4;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  function automatic logic [N_REG-1:0] onehot(input reg_idx_t idx);
    return {{(N_REG-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational 4-way round-robin picker; search starts at last+1.
// Revision : 1.0
// ============================================================================
module rr_pick
  import minibit_bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  reg_idx_t         last,
  output logic             valid,
  output reg_idx_t         winner
);

  logic [N_REQ-1:0] w_eff;
  reg_idx_t         w_idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_eff  = req & ~mask;
    valid  = 1'b0;
    winner = last;
    w_idx  = last;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = last + i[1:0];
      if (w_eff[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter and GRANT/LOAD/RELEASE transfer sequencer.
// Revision : 1.0
// ============================================================================
module bus_arbiter
  import minibit_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_src,
  input  logic [2*N_REQ-1:0]   req_dst,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REG-1:0]     oe_n,
  output logic [N_REG-1:0]     cp,
  output logic [N_REQ-1:0]     ack,
  output logic                 err,
  output logic                 busy
);

  state_t           r_state;
  reg_idx_t         r_win;
  reg_idx_t         r_last;
  reg_idx_t         r_dst;
  logic             r_same;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REG-1:0] r_oe_n;
  logic [N_REG-1:0] r_cp;
  logic [N_REQ-1:0] r_ack;
  logic             r_err;
  logic             r_busy;

  logic             w_valid;
  reg_idx_t         w_pick;
  logic [N_REQ-1:0] w_mask;
  reg_idx_t         w_src;
  reg_idx_t         w_dst;
  logic             w_same;

  // The requester just served is masked so a lingering req is not re-granted.
  assign w_mask = (r_state == RELEASE) ? onehot(r_win) : '0;

  rr_pick u_rr_pick (
    .req    (req),
    .mask   (w_mask),
    .last   (r_last),
    .valid  (w_valid),
    .winner (w_pick)
  );

  assign w_src  = req_src[{w_pick, 1'b0} +: 2];
  assign w_dst  = req_dst[{w_pick, 1'b0} +: 2];
  assign w_same = (w_src == w_dst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_win   <= 2'd3;
      r_last  <= 2'd3;
      r_dst   <= 2'd0;
      r_same  <= 1'b0;
      r_gnt   <= '0;
      r_oe_n  <= '1;
      r_cp    <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        IDLE, RELEASE: begin
          if (w_valid) begin
            r_state <= GRANT;
            r_win   <= w_pick;
            r_last  <= w_pick;
            r_dst   <= w_dst;
            r_same  <= w_same;
            r_gnt   <= onehot(w_pick);
            r_oe_n  <= w_same ? '1 : ~onehot(w_src);
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          r_state <= LOAD;
          r_cp    <= r_same ? '0 : onehot(r_dst);
          r_err   <= r_same;
        end
        LOAD: begin
          r_state <= RELEASE;
          r_gnt   <= '0;
          r_oe_n  <= '1;
          r_cp    <= '0;
          r_ack   <= onehot(r_win);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign oe_n = r_oe_n;
  assign cp   = r_cp;
  assign ack  = r_ack;
  assign err  = r_err;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] req_src;
  logic [7:0] req_dst;
  logic [3:0] gnt;
  logic [3:0] oe_n;
  logic [3:0] cp;
  logic [3:0] ack;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] oe_n;
    logic [3:0] cp;
    logic [3:0] ack;
    logic       err;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [7:0] src;
    logic [7:0] dst;
    logic [1:0] win;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  bus_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_src (req_src),
    .req_dst (req_dst),
    .gnt     (gnt),
    .oe_n    (oe_n),
    .cp      (cp),
    .ack     (ack),
    .err     (err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected GRANT, LOAD and RELEASE cycles of one transfer.
  task automatic push_xfer(input logic [1:0] w, input logic [7:0] s8, input logic [7:0] d8);
    logic [1:0] s;
    logic [1:0] d;
    logic       same;
    logic [3:0] oe;
    exp_t       e;
    s    = s8[{w, 1'b0} +: 2];
    d    = d8[{w, 1'b0} +: 2];
    same = (s == d);
    oe   = same ? 4'hF : ~(4'b0001 << s);
    e = '{gnt: 4'b0001 << w, oe_n: oe, cp: 4'h0, ack: 4'h0, err: 1'b0, busy: 1'b1};
    sb.push_back(e);
    e = '{gnt: 4'b0001 << w, oe_n: oe, cp: same ? 4'h0 : (4'b0001 << d),
          ack: 4'h0, err: same, busy: 1'b1};
    sb.push_back(e);
    e = '{gnt: 4'h0, oe_n: 4'hF, cp: 4'h0, ack: 4'b0001 << w, err: 1'b0, busy: 1'b1};
    sb.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e = '{gnt: 4'h0, oe_n: 4'hF, cp: 4'h0, ack: 4'h0, err: 1'b0, busy: 1'b0};
    sb.push_back(e);
  endtask

  task automatic check_next(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if ({gnt, oe_n, cp, ack, err, busy} !== e) begin
        errors++;
        $display("FAIL %s: got gnt=%b oe_n=%b cp=%b ack=%b err=%b busy=%b, want gnt=%b oe_n=%b cp=%b ack=%b err=%b busy=%b",
                 name, gnt, oe_n, cp, ack, err, busy,
                 e.gnt, e.oe_n, e.cp, e.ack, e.err, e.busy);
      end
    end
  endtask

  // One-hot invariants on every cycle.
  always @(negedge clk) begin
    checks++;
    if ($countones(gnt) > 1 || $countones(~oe_n) > 1 ||
        $countones(cp) > 1 || $countones(ack) > 1) begin
      errors++;
      $display("FAIL onehot_invariant: gnt=%b oe_n=%b cp=%b ack=%b, want at most one active bit each",
               gnt, oe_n, cp, ack);
    end
  end

  initial begin
    // requester fields {r3,r2,r1,r0}: src 1,0,3,2 / dst 2,3,3,1 (r1 is src==dst)
    vecs[0] = '{4'b0001, 8'h4E, 8'hBD, 2'd0};
    vecs[1] = '{4'b0100, 8'h4E, 8'hBD, 2'd2};
    vecs[2] = '{4'b1000, 8'h4E, 8'hBD, 2'd3};
    vecs[3] = '{4'b0010, 8'h4E, 8'hBD, 2'd1};
    vecs[4] = '{4'b0110, 8'h4E, 8'hBD, 2'd2};
    vecs[5] = '{4'b0011, 8'h4E, 8'hBD, 2'd0};
    vecs[6] = '{4'b1111, 8'h4E, 8'hBD, 2'd1};
    vecs[7] = '{4'b1001, 8'h4E, 8'hBD, 2'd3};
    vecs[8] = '{4'b0011, 8'h4E, 8'hBD, 2'd0};
    vecs[9] = '{4'b0011, 8'h4E, 8'hBD, 2'd1};

    rst_n   = 1'b0;
    req     = 4'h0;
    req_src = 8'h4E;
    req_dst = 8'hBD;
    repeat (2) @(negedge clk);
    push_idle();
    check_next("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    push_idle();
    check_next("idle_after_reset");

    // All four requesting; each drops req on the edge after its ack.
    req = 4'b1111;
    for (int j = 0; j < 4; j++) push_xfer(j[1:0], req_src, req_dst);
    push_idle();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      check_next($sformatf("b2b_c%0d", k));
      if (k % 3 == 2 && k < 12) req[k / 3] = 1'b0;
    end

    for (int v = 0; v < 10; v++) begin
      req     = vecs[v].req;
      req_src = vecs[v].src;
      req_dst = vecs[v].dst;
      push_xfer(vecs[v].win, vecs[v].src, vecs[v].dst);
      push_idle();
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check_next($sformatf("vec%0d_c%0d", v, c));
        if (c == 2) req = 4'h0;
      end
    end

    // src/dst changes after the grant must not affect the transfer.
    req = 4'b0001;
    push_xfer(2'd0, 8'h4E, 8'hBD);
    push_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_next($sformatf("latch_c%0d", c));
      if (c == 0) begin
        req_src = 8'h00;
        req_dst = 8'hFF;
      end
      if (c == 2) begin
        req     = 4'h0;
        req_src = 8'h4E;
        req_dst = 8'hBD;
      end
    end

    // req dropped right after the grant still completes with ack.
    req = 4'b0100;
    push_xfer(2'd2, req_src, req_dst);
    push_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_next($sformatf("drop_c%0d", c));
      if (c == 0) req = 4'h0;
    end

    // Asynchronous reset in the middle of LOAD.
    req = 4'b1000;
    push_xfer(2'd3, req_src, req_dst);
    void'(sb.pop_back());
    @(negedge clk);
    check_next("rst_grant");
    @(negedge clk);
    check_next("rst_load");
    rst_n = 1'b0;
    #1;
    push_idle();
    check_next("rst_async_clear");
    @(negedge clk);
    push_idle();
    check_next("rst_no_ack");
    rst_n = 1'b1;
    req   = 4'b1001;
    push_xfer(2'd0, req_src, req_dst);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_next($sformatf("post_rst_c%0d", c));
      if (c == 2) req = 4'h0;
    end
    // requester 3 still waiting: it is served next, then idle
    req = 4'b1000;
    push_xfer(2'd3, req_src, req_dst);
    push_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_next($sformatf("post_rst_r3_c%0d", c));
      if (c == 2) req = 4'h0;
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and transfer sequencer for the shared 8-bit tri-state data bus. Up to four requesters each ask for one register-to-register move. The arbiter grants one requester at a time, drives the active-low output enable of the source octal register onto the bus, and pulses the clock input of the destination register. Between transfers it guarantees a bus-idle cycle so that two drivers never overlap. It sits between the control logic and the bank of octal D registers and replaces the hand-wired enable and clock logic around them.

## Interface
- N_REQ, 4: number of requesters; fixed at 4 in this revision.
- N_REG, 4: number of bus registers; src/dst fields are 2 bits wide.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  transfer request, one bit per requester.
- req_src  input  8  2-bit source register index per requester; requester i uses bits [2i+1:2i].
- req_dst  input  8  2-bit destination register index per requester; same packing as req_src.
- gnt  output  4  one-hot grant; high during GRANT and LOAD.
- oe_n  output  4  active-low register output enables; at most one bit is low.
- cp  output  4  register clock strobes; at most one bit is high, for exactly one cycle.
- ack  output  4  one-cycle completion pulse to the served requester.
- err  output  1  one-cycle pulse when a granted transfer has src == dst.
- busy  output  1  high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE: if any req bit is set, go to GRANT; otherwise stay in IDLE.
  - GRANT: go to LOAD.
  - LOAD: go to RELEASE.
  - RELEASE: if any unmasked req bit is set, go to GRANT; otherwise go to IDLE.
- Arbitration happens in IDLE and RELEASE.
  - Priority rotates: the search starts at requester (last+1) mod 4, where last is the most recently granted requester.
  - After reset, last = 3, so requester 0 has top priority.
- At the arbitration edge the winner's src and dst fields are latched. Later changes to req, req_src or req_dst do not affect a transfer in flight.
- GRANT: gnt[w] = 1 and oe_n[src] = 0. This cycle lets the bus settle.
- LOAD: gnt[w] = 1, oe_n[src] = 0 and cp[dst] = 1. The destination register captures the bus.
- RELEASE: gnt = 0, oe_n = 4'hF, cp = 0, ack[w] = 1.
- In RELEASE, arbitration masks requester w, so a requester that is still holding req in its ack cycle is not re-granted. The requester must deassert req on the clock edge that follows ack.
- src == dst: the transfer is granted and sequenced normally, except that oe_n stays 4'hF and cp stays 0. err pulses in LOAD, and ack is still issued in RELEASE.
- If req[w] drops after the grant, the transfer still completes and ack is still issued.
- Reset (asynchronous, at any time, including mid-transfer): state = IDLE, last = 3, gnt = 0, oe_n = 4'hF, cp = 0, ack = 0, err = 0, busy = 0. A transfer aborted by reset produces no ack.

## Timing
- All outputs are registered. There is no combinational path from req to any output.
- Latency: req rises before edge n. Then:
  - GRANT is visible in cycle n+1.
  - cp is high in cycle n+2.
  - ack is high in cycle n+3.
- Throughput: back-to-back transfers take 3 cycles each (GRANT, LOAD, RELEASE). There is exactly one all-high oe_n cycle between two drivers.
- cp is high only in LOAD, and oe_n[src] is low through both GRANT and LOAD. The destination therefore sees stable data for a full cycle before and during its strobe.
- Invariants, checked every cycle:
  - popcount(gnt) ≤ 1.
  - popcount(~oe_n) ≤ 1.
  - popcount(cp) ≤ 1.
  - popcount(ack) ≤ 1.
  - cp ≠ 0 implies state == LOAD.

## Structure
- Package minibit_bus_pkg holds:
  - the state enum: IDLE, GRANT, LOAD, RELEASE;
  - N_REQ and N_REG;
  - the 2-bit register index type.
- Sub-module rr_pick: a combinational 4-way round-robin picker.
  - Inputs: req, mask and last.
  - Outputs: valid and a 2-bit winner index.
  - It is instantiated once.
- Everything else (the FSM, the latched src/dst/winner, and the output decode) lives in bus_arbiter.

## Test plan
- Single request: req = 4'b0001, src = 2, dst = 1 → oe_n = 4'b1011 in cycles n+1 and n+2; cp = 4'b0010 in cycle n+2; ack = 4'b0001 in cycle n+3; then IDLE.
- All four requesting continuously, each deasserting req after its ack → grant order 0, 1, 2, 3; a new GRANT every 3 cycles; oe_n = 4'hF in every RELEASE cycle.
- After requester 1 has been served, raise req = 4'b0011 → requester 0 wins if last = 3; if last = 0, requester 1 wins. Confirm that the rotation pointer advances.
- src == dst == 3 → no oe_n bit goes low and no cp pulse; err pulses in LOAD; ack is still issued.
- Change req_src and req_dst during GRANT → the originally latched src and dst are used.
- Assert rst_n = 0 in the middle of LOAD → immediately cp = 0, oe_n = 4'hF, gnt = 0, no ack. After reset is released, requester 0 has top priority.
